// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared constants, state encoding and helpers for the MIPS data-memory controller
//
// Purpose : access-size codes, controller state encoding, lane widths and the
//           alignment check shared by data_memory_ctrl and mem_lane_align.
// Ports   : none (package).
package mips_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Size code 2'b11 is treated as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic mis;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = lane[0];
            default:   mis = (lane != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte/half/word store merge and load extract/extend
//
// Purpose : purely combinational lane handling for one 32-bit little-endian word.
// Ports   : old_word    - current contents of the addressed word
//           wdata       - right-aligned store data
//           size        - access size code (byte/half/word, 2'b11 = word)
//           lane        - byte address bits [1:0]
//           signed_ld   - sign-extend byte/half loads
//           merged_word - old_word with only the addressed lanes replaced
//           load_data   - right-aligned, zero/sign-extended load result
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] wdata,
    input  logic [1:0]        size,
    input  logic [1:0]        lane,
    input  logic              signed_ld,
    output logic [WORD_W-1:0] merged_word,
    output logic [WORD_W-1:0] load_data
);

    logic [BYTE_W-1:0] byte_v;
    logic [HALF_W-1:0] half_v;

    always_comb begin
        merged_word = old_word;
        load_data   = old_word;
        byte_v      = old_word[{lane, 3'b000} +: BYTE_W];
        half_v      = lane[1] ? old_word[31:16] : old_word[15:0];
        case (size)
            SIZE_BYTE: begin
                merged_word[{lane, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
                load_data = {{(WORD_W-BYTE_W){signed_ld & byte_v[BYTE_W-1]}}, byte_v};
            end
            SIZE_HALF: begin
                if (lane[1]) begin
                    merged_word[31:16] = wdata[HALF_W-1:0];
                end else begin
                    merged_word[15:0] = wdata[HALF_W-1:0];
                end
                load_data = {{(WORD_W-HALF_W){signed_ld & half_v[HALF_W-1]}}, half_v};
            end
            default: begin
                merged_word = wdata;
                load_data   = old_word;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - MIPS data-memory controller with wait states and clear-on-reset
//
// Purpose : DEPTH x 32-bit byte-addressed data memory serving LB/LBU/LH/LHU/LW/SB/SH/SW
//           through a REQ/READY handshake, with an optional zeroing sweep after reset.
// Ports   : CLK, RESET_N (async, active-low)
//           REQ, WE, SIZE, SIGNED_LD, ADDR, WRITE_DATA - request, sampled only in IDLE
//           READ_DATA, READY, ERR_MISALIGN, ERR_RANGE   - response, valid with READY
//           BUSY                                         - clearing or request in flight
//           DBG_ADDR / DBG_DATA                          - combinational debug word read
module data_memory_ctrl
    import mips_mem_pkg::*;
#(
    parameter int DEPTH          = 256,
    parameter int WAIT_CYCLES    = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     REQ,
    input  logic                     WE,
    input  logic [1:0]               SIZE,
    input  logic                     SIGNED_LD,
    input  logic [31:0]              ADDR,
    input  logic [31:0]              WRITE_DATA,
    output logic [31:0]              READ_DATA,
    output logic                     READY,
    output logic                     BUSY,
    output logic                     ERR_MISALIGN,
    output logic                     ERR_RANGE,
    input  logic [$clog2(DEPTH)-1:0] DBG_ADDR,
    output logic [31:0]              DBG_DATA
);

    localparam int     AW          = $clog2(DEPTH);
    localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          sgn_q, sgn_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          mis_q, mis_d;
    logic          rng_q, rng_d;

    logic [31:0]   mem_q [DEPTH];

    logic          mem_we;
    logic [AW-1:0] mem_widx;
    logic [31:0]   mem_wword;
    logic          do_resp;

    // With WAIT_CYCLES=0 the response is produced on the sampling edge itself,
    // so the request fields come straight from the ports while in IDLE.
    logic          cur_we;
    logic [1:0]    cur_size;
    logic          cur_sgn;
    logic [31:0]   cur_addr;
    logic [31:0]   cur_wdata;
    logic [AW-1:0] cur_widx;
    logic          cur_mis;
    logic          cur_rng;
    logic [31:0]   merged_word;
    logic [31:0]   load_data;

    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_we    = WE;
            cur_size  = SIZE;
            cur_sgn   = SIGNED_LD;
            cur_addr  = ADDR;
            cur_wdata = WRITE_DATA;
        end else begin
            cur_we    = we_q;
            cur_size  = size_q;
            cur_sgn   = sgn_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
    end

    assign cur_widx = cur_addr[AW+1:2];
    assign cur_mis  = is_misaligned(cur_size, cur_addr[1:0]);
    assign cur_rng  = |cur_addr[31:AW+2];

    mem_lane_align u_align (
        .old_word    (mem_q[cur_widx]),
        .wdata       (cur_wdata),
        .size        (cur_size),
        .lane        (cur_addr[1:0]),
        .signed_ld   (cur_sgn),
        .merged_word (merged_word),
        .load_data   (load_data)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        size_d    = size_q;
        sgn_d     = sgn_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        mis_d     = 1'b0;
        rng_d     = 1'b0;
        mem_we    = 1'b0;
        mem_widx  = cur_widx;
        mem_wword = merged_word;
        do_resp   = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_widx  = ptr_q;
                mem_wword = '0;
                ptr_d     = ptr_q + 1'b1;
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end
            end
            ST_IDLE: begin
                if (REQ) begin
                    we_d    = WE;
                    size_d  = SIZE;
                    sgn_d   = SIGNED_LD;
                    addr_d  = ADDR;
                    wdata_d = WRITE_DATA;
                    if (WAIT_CYCLES == 0) begin
                        do_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    do_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Response edge: commit the store and register the load result / error flags.
        if (do_resp) begin
            state_d = ST_RESP;
            mis_d   = cur_mis;
            rng_d   = !cur_mis && cur_rng;
            if (cur_mis || cur_rng) begin
                rdata_d = '0;
            end else if (cur_we) begin
                rdata_d = '0;
                mem_we  = 1'b1;
            end else begin
                rdata_d = load_data;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= RESET_STATE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= SIZE_BYTE;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            rng_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            rng_q   <= rng_d;
        end
    end

    // Storage is not reset so contents survive reset when CLEAR_ON_RESET=0;
    // writes are suppressed while reset is held.
    always_ff @(posedge CLK) begin
        if (mem_we && RESET_N) begin
            mem_q[mem_widx] <= mem_wword;
        end
    end

    assign READ_DATA    = rdata_q;
    assign READY        = (state_q == ST_RESP);
    assign BUSY         = (state_q != ST_IDLE);
    assign ERR_MISALIGN = mis_q;
    assign ERR_RANGE    = rng_q;
    assign DBG_DATA     = mem_q[DBG_ADDR];

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - directed self-checking bench for data_memory_ctrl
module tb_data_memory_ctrl;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        REQ0, REQ1;
    logic        WE, SIGNED_LD;
    logic [1:0]  SIZE;
    logic [31:0] ADDR, WRITE_DATA;
    logic [3:0]  dbg0;
    logic [7:0]  dbg1;

    logic [31:0] rd0, dd0, rd1, dd1;
    logic        rdy0, busy0, mis0, rng0;
    logic        rdy1, busy1, mis1, rng1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    data_memory_ctrl #(.DEPTH(16), .WAIT_CYCLES(2), .CLEAR_ON_RESET(1)) u0 (
        .CLK(CLK), .RESET_N(RESET_N), .REQ(REQ0), .WE(WE), .SIZE(SIZE),
        .SIGNED_LD(SIGNED_LD), .ADDR(ADDR), .WRITE_DATA(WRITE_DATA),
        .READ_DATA(rd0), .READY(rdy0), .BUSY(busy0), .ERR_MISALIGN(mis0),
        .ERR_RANGE(rng0), .DBG_ADDR(dbg0), .DBG_DATA(dd0)
    );

    data_memory_ctrl #(.DEPTH(256), .WAIT_CYCLES(0), .CLEAR_ON_RESET(1)) u1 (
        .CLK(CLK), .RESET_N(RESET_N), .REQ(REQ1), .WE(WE), .SIZE(SIZE),
        .SIGNED_LD(SIGNED_LD), .ADDR(ADDR), .WRITE_DATA(WRITE_DATA),
        .READ_DATA(rd1), .READY(rdy1), .BUSY(busy1), .ERR_MISALIGN(mis1),
        .ERR_RANGE(rng1), .DBG_ADDR(dbg1), .DBG_DATA(dd1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic dbg_chk0(input string tag, input logic [3:0] idx, input logic [31:0] exp);
        dbg0 = idx;
        #1;
        check(tag, dd0, exp);
    endtask

    // One access on u0 (WAIT_CYCLES=2), called at a falling edge. Request inputs
    // are scrambled once the request has been sampled.
    task automatic do0(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_mis, input logic exp_rng);
        int lat;
        WE = we; SIZE = sz; SIGNED_LD = sg; ADDR = a; WRITE_DATA = wd; REQ0 = 1'b1;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
            REQ0 = 1'b0; WE = ~we; SIZE = ~sz; SIGNED_LD = ~sg;
            ADDR = 32'hFFFF_FFFF; WRITE_DATA = ~wd;
        end while (!rdy0 && lat < 20);
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_rdata"}, rd0, exp_rd);
        check({tag, "_misalign"}, {31'd0, mis0}, {31'd0, exp_mis});
        check({tag, "_range"}, {31'd0, rng0}, {31'd0, exp_rng});
        @(negedge CLK);
        check({tag, "_ready_drop"}, {31'd0, rdy0}, 32'd0);
        check({tag, "_rdata_hold"}, rd0, exp_rd);
        check({tag, "_err_clear"}, {30'd0, mis0, rng0}, 32'd0);
    endtask

    initial begin
        int          bc;
        int          k;
        logic        saw_rdy;
        logic [5:0]  mask;
        logic [31:0] rdv;

        RESET_N = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0; WE = 1'b0; SIGNED_LD = 1'b0;
        SIZE = 2'b00; ADDR = '0; WRITE_DATA = '0; dbg0 = '0; dbg1 = '0;
        repeat (2) @(negedge CLK);
        check("rst_ready", {31'd0, rdy0}, 32'd0);
        check("rst_rdata", rd0, 32'd0);
        check("rst_busy", {31'd0, busy0}, 32'd1);
        check("rst_err", {30'd0, mis0, rng0}, 32'd0);

        // Clear sweep: BUSY for exactly 16 cycles, REQ ignored throughout.
        RESET_N = 1'b1;
        REQ0 = 1'b1; WE = 1'b1; SIZE = 2'b10; ADDR = 32'h4; WRITE_DATA = 32'h5555_5555;
        bc = busy0 ? 1 : 0;
        saw_rdy = 1'b0;
        k = 0;
        while (k < 40) begin
            @(negedge CLK);
            k++;
            saw_rdy = saw_rdy | rdy0;
            if (busy0) bc++;
            else break;
        end
        REQ0 = 1'b0;
        check("clear_busy_cycles", 32'(bc), 32'd16);
        check("clear_no_ready", {31'd0, saw_rdy}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            dbg_chk0($sformatf("clear_word%0d", i), 4'(i), 32'd0);
        end
        @(negedge CLK);

        do0("sw_08", 1'b1, 2'b10, 1'b0, 32'h8, 32'h8899_AABB, 32'd0, 1'b0, 1'b0);
        dbg_chk0("sw_08_word2", 4'd2, 32'h8899_AABB);
        do0("lb_09_s", 1'b0, 2'b00, 1'b1, 32'h9, 32'h0, 32'hFFFF_FFAA, 1'b0, 1'b0);
        do0("lbu_09", 1'b0, 2'b00, 1'b0, 32'h9, 32'h0, 32'h0000_00AA, 1'b0, 1'b0);
        do0("sh_0a", 1'b1, 2'b01, 1'b0, 32'hA, 32'hFFFF_1234, 32'd0, 1'b0, 1'b0);
        dbg_chk0("sh_0a_word2", 4'd2, 32'h1234_AABB);
        do0("lhu_0a", 1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 32'h0000_1234, 1'b0, 1'b0);
        do0("lh_08_s", 1'b0, 2'b01, 1'b1, 32'h8, 32'h0, 32'hFFFF_AABB, 1'b0, 1'b0);
        do0("lb_0b_s", 1'b0, 2'b00, 1'b1, 32'hB, 32'h0, 32'h0000_0012, 1'b0, 1'b0);
        do0("sb_03", 1'b1, 2'b00, 1'b0, 32'h3, 32'h0000_005A, 32'd0, 1'b0, 1'b0);
        dbg_chk0("sb_03_word0", 4'd0, 32'h5A00_0000);
        do0("lw_00_s", 1'b0, 2'b10, 1'b1, 32'h0, 32'h0, 32'h5A00_0000, 1'b0, 1'b0);
        do0("lw11_08_s", 1'b0, 2'b11, 1'b1, 32'h8, 32'h0, 32'h1234_AABB, 1'b0, 1'b0);
        do0("lw_06_mis", 1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 32'd0, 1'b1, 1'b0);
        do0("sw_400_rng", 1'b1, 2'b10, 1'b0, 32'h400, 32'h7777_7777, 32'd0, 1'b0, 1'b1);
        dbg_chk0("sw_400_word0_kept", 4'd0, 32'h5A00_0000);
        do0("sh_401_prio", 1'b1, 2'b01, 1'b0, 32'h401, 32'h0000_6666, 32'd0, 1'b1, 1'b0);
        dbg_chk0("sh_401_word0_kept", 4'd0, 32'h5A00_0000);

        // u1: WAIT_CYCLES=0, back-to-back requests with REQ held high.
        @(negedge CLK);
        k = 0;
        while (busy1 && k < 600) begin
            @(negedge CLK);
            k++;
        end
        check("u1_clear_done", {31'd0, busy1}, 32'd0);
        WE = 1'b1; SIZE = 2'b10; SIGNED_LD = 1'b0; ADDR = 32'h10; WRITE_DATA = 32'hCAFE_F00D;
        REQ1 = 1'b1;
        mask = '0;
        rdv = '0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge CLK);
            mask[i-1] = rdy1;
            if (i == 1) WE = 1'b0;
            if (i == 3) rdv = rd1;
        end
        REQ1 = 1'b0;
        check("u1_b2b_ready_pattern", {26'd0, mask}, 32'b010101);
        check("u1_b2b_load", rdv, 32'hCAFE_F00D);

        WE = 1'b1; ADDR = 32'h400; WRITE_DATA = 32'h1111_1111; REQ1 = 1'b1;
        @(negedge CLK);
        REQ1 = 1'b0;
        check("u1_rng_ready", {31'd0, rdy1}, 32'd1);
        check("u1_rng_flags", {30'd0, mis1, rng1}, 32'd1);
        check("u1_rng_rdata", rd1, 32'd0);
        dbg1 = 8'd0;
        #1;
        check("u1_rng_word0_kept", dd1, 32'd0);
        dbg1 = 8'd4;
        #1;
        check("u1_word4", dd1, 32'hCAFE_F00D);
        @(negedge CLK);

        // Reset in the middle of a u0 store's WAIT: no response, no write, clear restarts.
        WE = 1'b1; SIZE = 2'b10; ADDR = 32'h4; WRITE_DATA = 32'hDEAD_BEEF; REQ0 = 1'b1;
        @(negedge CLK);
        REQ0 = 1'b0;
        check("midwait_busy", {31'd0, busy0}, 32'd1);
        RESET_N = 1'b0;
        @(negedge CLK);
        check("midwait_no_ready", {31'd0, rdy0}, 32'd0);
        RESET_N = 1'b1;
        dbg0 = 4'd2;
        bc = busy0 ? 1 : 0;
        saw_rdy = 1'b0;
        k = 0;
        while (k < 40) begin
            @(negedge CLK);
            k++;
            saw_rdy = saw_rdy | rdy0;
            if (k == 1) check("restart_w2_kept_c1", dd0, 32'h1234_AABB);
            if (k == 2) check("restart_w2_kept_c2", dd0, 32'h1234_AABB);
            if (k == 3) check("restart_w2_cleared_c3", dd0, 32'd0);
            if (busy0) bc++;
            else break;
        end
        check("restart_busy_cycles", 32'(bc), 32'd16);
        check("restart_no_ready", {31'd0, saw_rdy}, 32'd0);
        dbg_chk0("restart_word1_no_store", 4'd1, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised data-memory controller for the MIPS datapath: word array of DEPTH x 32 bits, byte-addressed.
- Serves LB/LBU/LH/LHU/LW/SB/SH/SW via a REQ/READY handshake with configurable wait states.
- Optional clear-on-reset sequencer; a single debug read port replaces per-word output buses.
- Sits between the MEM pipeline stage and storage; the stage stalls on !READY.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, 4..4096.
- WAIT_CYCLES, 1, extra cycles between acceptance and response, 0..15.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset (BUSY during clear); 0 = contents retained across reset.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- REQ  in  1  access request, sampled only in IDLE.
- WE  in  1  1 = store, 0 = load.
- SIZE  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- SIGNED_LD  in  1  sign-extend byte/half loads.
- ADDR  in  32  byte address.
- WRITE_DATA  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- READ_DATA  out  32  load result, right-aligned and extended.
- READY  out  1  one-cycle response strobe.
- BUSY  out  1  high while clearing or while a request is in flight.
- ERR_MISALIGN  out  1  valid with READY.
- ERR_RANGE  out  1  valid with READY.
- DBG_ADDR  in  clog2(DEPTH)  debug word index.
- DBG_DATA  out  32  combinational read of word DBG_ADDR.

Behaviour:
- Reset (RESET_N low, async):
  - READ_DATA=0, READY=0, ERR_*=0.
  - State = CLEAR if CLEAR_ON_RESET, else IDLE.
  - BUSY=CLEAR_ON_RESET; clear pointer=0.
- CLEAR state:
  - Writes word[ptr]=0 each cycle; ptr increments.
  - After word DEPTH-1 is written, go to IDLE; BUSY falls on the same edge.
  - Clear lasts exactly DEPTH cycles. REQ is ignored throughout.
  - Reset asserted mid-clear restarts the clear from word 0.
- IDLE:
  - REQ=1 at edge T latches WE, SIZE, SIGNED_LD, ADDR, WRITE_DATA; go to WAIT with counter=WAIT_CYCLES. BUSY=1 from T.
- WAIT:
  - Decrement counter each cycle; at 0 go to RESP.
  - With WAIT_CYCLES=0, WAIT is skipped and RESP is entered at T+1.
  - Inputs are not re-sampled; input changes during WAIT have no effect.
- RESP (one cycle):
  - READY=1; store commits at entry to RESP; READ_DATA/ERR_* update on the same edge.
  - Response edge = T + WAIT_CYCLES + 1.
  - Next state is IDLE and BUSY=0. The next REQ is sampled in IDLE, so at most one access per WAIT_CYCLES+2 cycles.
- Addressing and lanes:
  - Word index = ADDR[clog2(DEPTH)+1:2]; lane = ADDR[1:0].
  - Little-endian: lane k = bits [8k+7:8k]. Half at ADDR[1]=h occupies [16h+15:16h].
- Stores: byte-enable merge; only the addressed byte/half lanes change. READ_DATA=0 on a store response.
- Loads: extract the lane; zero-extend, or sign-extend when SIGNED_LD=1 (SIGNED_LD is ignored for word loads).
- Errors: checked on latched values; misalign is reported with priority over range.
  - ERR_MISALIGN: half with ADDR[0]=1, or word with ADDR[1:0]!=0.
  - ERR_RANGE: ADDR[31:clog2(DEPTH)+2] != 0.
  - On any error: no write, READ_DATA=0, READY still pulses, and the flag is high with READY only.
- Hold: READ_DATA holds its value until the next response. ERR_* are 0 outside RESP.
- DBG_DATA: reflects committed contents (including partially completed clears) with no latency.

Decomposition:
- Package mips_mem_pkg:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD constants.
  - State encoding CLEAR/IDLE/WAIT/RESP.
  - Lane-width constants.
- Sub-module mem_lane_align (combinational): store merge (old word, data, size, lane → new word) and load extract/extend. This is the only natural split; it is unit-testable standalone.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH=16:
  - BUSY high for exactly 16 cycles; REQ during clear produces no READY.
  - Afterwards DBG_DATA=0 for all 16 indices.
- SW ADDR=0x8, data 0x8899AABB; then LB ADDR=0x9 with SIGNED_LD=1, WAIT_CYCLES=2:
  - Store READY at T+3.
  - Load READ_DATA=0xFFFFFFAA; with SIGNED_LD=0 the load returns 0x000000AA.
- SH ADDR=0xA, data 0x1234 over word 0x8899AABB → DBG_DATA[2]=0x1234AABB; then LH ADDR=0xA returns 0x00001234.
- LW ADDR=0x6 → READY with ERR_MISALIGN=1, READ_DATA=0. SW ADDR=0x400 with DEPTH=256 → ERR_RANGE=1 and no word changed.
- WAIT_CYCLES=0, two back-to-back REQs held high → READY at T+1 and T+3.
- RESET_N low mid-WAIT of a store → no READY, no write; clear restarts at word 0.
